mac_da_lookup: RTL and testbench
================================

Name: mac_da_lookup

Overview:
Destination-side reader of the switch MAC table: the counterpart to the source-address learner.
- Captures the destination MAC (DA) from the ingress byte stream and issues one read to the MAC table's read port.
- Checks the entry's age and emits a per-frame forwarding decision: unicast port mask, flood, or filter.
- Sits between the ingress receive path and the egress queue arbiter.

Parameters:
pADRESS, 2, width of port number
pPORTS, 4, number of switch ports (2**pADRESS)
pSLOTS, 16384, MAC table entries; index width is $clog2(pSLOTS)=14
pDATA_WIDTH, 8, ingress byte width
pTIME, 9, width of the table age field

Ports:
iclk  in  1  clock
irst  in  1  synchronous active-high reset
i_dv  in  1  ingress byte valid; high for the frame's contiguous bytes, starting at DA byte 0 (preamble/SFD already stripped)
irx_d  in  pDATA_WIDTH  ingress byte
i_port_num  in  pADRESS  ingress port, sampled with DA byte 0
o_tbl_addr  out  14  table read address
o_tbl_rd  out  1  one-cycle read strobe
i_tbl_port  in  pADRESS  stored port; valid exactly 1 cycle after o_tbl_rd
i_tbl_time  in  pTIME  stored age; 0 = expired; same timing as i_tbl_port
o_fwd_valid  out  1  decision valid; held until accepted
i_fwd_ready  in  1  egress arbiter accepts the decision
o_fwd_mask  out  pPORTS  egress port mask
o_fwd_flood  out  1  decision is a flood
o_drop_cnt  out  16  frames skipped while a decision was pending; saturates at 16'hFFFF

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, byte counter 0, o_drop_cnt 0. Reset overrides every state, including mid-frame and HOLD; a pending decision is lost.
- Frame start: a frame starts on a rising edge of i_dv as seen by the block.
- FSM state IDLE:
  - i_dv=1 goes to DA and counts the byte as byte 0; i_port_num is latched.
  - If i_dv rises while in HOLD, the block goes to SKIP instead and o_drop_cnt increments.
- FSM state DA: bytes 0..5 are captured.
  - Multicast flag = byte0[0]. Broadcast flag = all six bytes 8'hFF.
  - Table address = {byte4[5:0], byte5}.
  - i_dv low before byte 5 (runt): return to IDLE with no decision and no read.
- FSM state LOOKUP: the cycle after byte 5 is sampled, o_tbl_rd=1 for exactly one cycle with o_tbl_addr. o_tbl_addr holds its value until the next lookup.
- FSM state RESP: latch i_tbl_port and i_tbl_time.
- FSM state DECIDE: priority order:
  1. Multicast or broadcast: flood; mask = all ones with the ingress bit cleared; o_fwd_flood=1.
  2. i_tbl_time==0: unknown DA; flood as above.
  3. i_tbl_port==ingress port: filter; mask=0, o_fwd_flood=0.
  4. Otherwise: one-hot mask of i_tbl_port.
- FSM state HOLD:
  - o_fwd_valid=1; mask and flood are held stable.
  - i_fwd_ready=1 completes the transfer in that cycle. The next state is SKIP if the frame is still in progress (i_dv=1), else IDLE.
  - A table read is always performed, even for broadcast, so latency is uniform.
- FSM state SKIP: wait for i_dv=0, then go to IDLE. Rest-of-frame bytes are ignored.
- Latency: byte 5 sampled at cycle N; o_tbl_rd at N+1; data at N+2; decision registered so o_fwd_valid=1 at N+3. If i_fwd_ready is already high, the decision is accepted at N+3.
- A frame starting while HOLD is pending is skipped in full (no capture, no read). The pending decision is unaffected.
- Simultaneous: i_fwd_ready=1 and a new i_dv rise in the same HOLD cycle counts as a skip, because the frame began before the block returned to IDLE.
- o_drop_cnt saturates at 16'hFFFF; it is cleared only by irst.

Decomposition:
- Shared package switch_pkg holds:
  - FSM state enum (IDLE, DA, LOOKUP, RESP, DECIDE, HOLD, SKIP)
  - lpBROADCAST = 48'hFFFF_FFFF_FFFF
  - lpDA_BYTES = 6
  - table index width constant
  - these are shared with the learner.
- Natural sub-module: fwd_mask_gen. It is combinational and takes flags, table data and ingress port, and returns the mask and flood bit. The FSM and capture stay in the top module.

Test Plan:
- Unicast hit: port1 frame, DA=00:11:22:33:04:56, table[0x0456] = {port 3, time 300} -> o_tbl_addr=14'h0456 at N+1; o_fwd_mask=4'b1000, flood=0, valid at N+3.
- Broadcast: port0 frame, DA=FF:FF:FF:FF:FF:FF -> mask=4'b1110, flood=1; read still issued at address 14'h3FFF.
- Aged entry: table time=0 for the addressed DA, ingress port 2 -> mask=4'b1011, flood=1.
- Same-port filter: ingress port 1, table port 1, time 5 -> valid with mask=4'b0000, flood=0.
- Backpressure and overrun: hold i_fwd_ready=0 and send a second frame -> o_drop_cnt=1, no second o_tbl_rd, first decision stable. Raising i_fwd_ready completes the first decision only.
- Runt and reset: i_dv drops after 3 DA bytes -> no o_tbl_rd, back to IDLE. irst asserted in HOLD -> o_fwd_valid=0 the next cycle, FSM in IDLE.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared MAC-table definitions used by the source learner and the destination lookup.
package switch_pkg;

  localparam int          lpDA_BYTES  = 6;
  localparam logic [47:0] lpBROADCAST = 48'hFFFF_FFFF_FFFF;
  localparam int          lpSLOTS     = 16384;
  localparam int          lpIDX_W     = $clog2(lpSLOTS);

  typedef enum logic [2:0] {
    IDLE,
    DA,
    LOOKUP,
    RESP,
    DECIDE,
    HOLD,
    SKIP
  } state_e;

endpackage

// File: rtl/fwd_mask_gen.sv
// Turns DA flags, the MAC-table response and the ingress port into an egress mask.
module fwd_mask_gen #(
  parameter int pADRESS = 2,
  parameter int pPORTS  = 2**pADRESS,
  parameter int pTIME   = 9
) (
  input  logic               mcast_i,
  input  logic               bcast_i,
  input  logic [pADRESS-1:0] tbl_port_i,
  input  logic [pTIME-1:0]   tbl_time_i,
  input  logic [pADRESS-1:0] ingress_port_i,
  output logic [pPORTS-1:0]  mask_o,
  output logic               flood_o
);

  logic [pPORTS-1:0] ingressBit;

  // Flooding never sends a frame back out of the port it arrived on.
  always_comb begin
    ingressBit                 = '0;
    ingressBit[ingress_port_i] = 1'b1;
    mask_o                     = '0;
    flood_o                    = 1'b0;
    if (mcast_i || bcast_i || (tbl_time_i == '0)) begin
      mask_o  = ~ingressBit;
      flood_o = 1'b1;
    end else if (tbl_port_i != ingress_port_i) begin
      mask_o[tbl_port_i] = 1'b1;
    end
  end

endmodule

// File: rtl/mac_da_lookup.sv
// Destination-address reader of the MAC table: captures the DA, issues one table
// read per frame and presents a held forwarding decision to the egress arbiter.
module mac_da_lookup
  import switch_pkg::*;
#(
  parameter int pADRESS     = 2,
  parameter int pPORTS      = 2**pADRESS,
  parameter int pSLOTS      = 16384,
  parameter int pDATA_WIDTH = 8,
  parameter int pTIME       = 9
) (
  input  logic                      iclk,
  input  logic                      irst,
  input  logic                      i_dv,
  input  logic [pDATA_WIDTH-1:0]    irx_d,
  input  logic [pADRESS-1:0]        i_port_num,
  output logic [$clog2(pSLOTS)-1:0] o_tbl_addr,
  output logic                      o_tbl_rd,
  input  logic [pADRESS-1:0]        i_tbl_port,
  input  logic [pTIME-1:0]          i_tbl_time,
  output logic                      o_fwd_valid,
  input  logic                      i_fwd_ready,
  output logic [pPORTS-1:0]         o_fwd_mask,
  output logic                      o_fwd_flood,
  output logic [15:0]               o_drop_cnt
);

  localparam int IDX_W = $clog2(pSLOTS);
  localparam int CNT_W = $clog2(lpDA_BYTES);
  localparam int DA_W  = lpDA_BYTES * pDATA_WIDTH;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               dv_q;
  logic [DA_W-1:0]    da_q;
  logic [pADRESS-1:0] port_q;
  logic [IDX_W-1:0]   addr_q;
  logic               rd_q;
  logic               valid_q;
  logic [pPORTS-1:0]  mask_q;
  logic               flood_q;
  logic [15:0]        drop_q;

  logic               dvRise;
  logic               mcast;
  logic               bcast;
  logic [15:0]        drop_d;
  logic [pPORTS-1:0]  genMask;
  logic               genFlood;

  assign dvRise = i_dv && !dv_q;
  assign mcast  = da_q[DA_W-pDATA_WIDTH];
  assign bcast  = (da_q == lpBROADCAST);
  assign drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

  fwd_mask_gen #(
    .pADRESS (pADRESS),
    .pPORTS  (pPORTS),
    .pTIME   (pTIME)
  ) u_mask_gen (
    .mcast_i        (mcast),
    .bcast_i        (bcast),
    .tbl_port_i     (i_tbl_port),
    .tbl_time_i     (i_tbl_time),
    .ingress_port_i (port_q),
    .mask_o         (genMask),
    .flood_o        (genFlood)
  );

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      da_q    <= '0;
      port_q  <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      mask_q  <= '0;
      flood_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      dv_q <= i_dv;
      case (state_q)
        IDLE: begin
          if (dvRise) begin
            da_q    <= {da_q[DA_W-pDATA_WIDTH-1:0], irx_d};
            port_q  <= i_port_num;
            cnt_q   <= CNT_W'(1);
            state_q <= DA;
          end
        end
        DA: begin
          if (!i_dv) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            da_q <= {da_q[DA_W-pDATA_WIDTH-1:0], irx_d};
            if (cnt_q == CNT_W'(lpDA_BYTES - 1)) begin
              // Index is {byte4[5:0], byte5}; the truncating cast drops byte4's top bits.
              addr_q  <= IDX_W'({da_q[pDATA_WIDTH-1:0], irx_d});
              rd_q    <= 1'b1;
              cnt_q   <= '0;
              state_q <= LOOKUP;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        LOOKUP: begin
          rd_q    <= 1'b0;
          state_q <= RESP;
        end
        // The decision is registered straight from the read response, so DECIDE folds into RESP.
        RESP: begin
          mask_q  <= genMask;
          flood_q <= genFlood;
          valid_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          if (dvRise) begin
            drop_q <= drop_d;
          end
          if (i_fwd_ready) begin
            valid_q <= 1'b0;
            mask_q  <= '0;
            flood_q <= 1'b0;
            state_q <= i_dv ? SKIP : IDLE;
          end
        end
        SKIP: begin
          if (!i_dv) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_tbl_addr  = addr_q;
  assign o_tbl_rd    = rd_q;
  assign o_fwd_valid = valid_q;
  assign o_fwd_mask  = mask_q;
  assign o_fwd_flood = flood_q;
  assign o_drop_cnt  = drop_q;

endmodule

// File: tb/tb_mac_da_lookup.sv
// Scenario bench for mac_da_lookup: expected decisions are queued as each frame is
// driven and compared when the DUT raises o_fwd_valid.
module tb_mac_da_lookup;

  logic        iclk = 1'b0;
  logic        irst;
  logic        i_dv;
  logic [7:0]  irx_d;
  logic [1:0]  i_port_num;
  logic [13:0] o_tbl_addr;
  logic        o_tbl_rd;
  logic [1:0]  i_tbl_port;
  logic [8:0]  i_tbl_time;
  logic        o_fwd_valid;
  logic        i_fwd_ready;
  logic [3:0]  o_fwd_mask;
  logic        o_fwd_flood;
  logic [15:0] o_drop_cnt;

  int          checks   = 0;
  int          failures = 0;
  int          expDrop  = 0;
  logic [4:0]  expQ[$];

  always #5 iclk = ~iclk;

  mac_da_lookup dut (
    .iclk        (iclk),
    .irst        (irst),
    .i_dv        (i_dv),
    .irx_d       (irx_d),
    .i_port_num  (i_port_num),
    .o_tbl_addr  (o_tbl_addr),
    .o_tbl_rd    (o_tbl_rd),
    .i_tbl_port  (i_tbl_port),
    .i_tbl_time  (i_tbl_time),
    .o_fwd_valid (o_fwd_valid),
    .i_fwd_ready (i_fwd_ready),
    .o_fwd_mask  (o_fwd_mask),
    .o_fwd_flood (o_fwd_flood),
    .o_drop_cnt  (o_drop_cnt)
  );

  // Drives one frame's DA, answers the single table read and checks the decision.
  task automatic frame_and_check(input logic [1:0] port, input logic [47:0] da,
                                 input logic [1:0] tPort, input logic [8:0] tTime,
                                 input logic [3:0] eMask, input logic eFlood,
                                 input logic ready, input int extra, input string name);
    logic [4:0] exp;
    i_fwd_ready = ready;
    for (int b = 0; b < 6; b++) begin
      @(negedge iclk);
      i_dv       = 1'b1;
      irx_d      = da[47-8*b -: 8];
      i_port_num = (b == 0) ? port : ~port;
    end
    expQ.push_back({eFlood, eMask});
    @(negedge iclk);
    irx_d = 8'hA5;
    checks++;
    if (o_tbl_rd !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_rd got=%b exp=1", name, o_tbl_rd);
    end
    checks++;
    if (o_tbl_addr !== da[13:0]) begin
      failures++;
      $display("[TB] FAIL %s_addr got=%h exp=%h", name, o_tbl_addr, da[13:0]);
    end
    @(negedge iclk);
    checks++;
    if (o_tbl_rd !== 1'b0 || o_fwd_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_gap got rd=%b valid=%b exp rd=0 valid=0", name, o_tbl_rd, o_fwd_valid);
    end
    i_tbl_port = tPort;
    i_tbl_time = tTime;
    @(negedge iclk);
    i_tbl_port = ~tPort;
    i_tbl_time = '0;
    checks++;
    if (o_fwd_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_valid got=%b exp=1", name, o_fwd_valid);
    end
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_queue got=empty exp=entry", name);
    end else begin
      exp = expQ.pop_front();
      checks++;
      if ({o_fwd_flood, o_fwd_mask} !== exp) begin
        failures++;
        $display("[TB] FAIL %s_decision got flood=%b mask=%b exp flood=%b mask=%b",
                 name, o_fwd_flood, o_fwd_mask, exp[4], exp[3:0]);
      end
    end
    i_dv = (extra > 0);
    @(negedge iclk);
    if (ready) begin
      checks++;
      if (o_fwd_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s_accept got valid=%b exp=0", name, o_fwd_valid);
      end
    end
    for (int k = 1; k < extra; k++) @(negedge iclk);
    i_dv  = 1'b0;
    irx_d = 8'h00;
  endtask

  task automatic test_reset;
    irst = 1'b1; i_dv = 1'b0; irx_d = '0; i_port_num = '0;
    i_tbl_port = '0; i_tbl_time = '0; i_fwd_ready = 1'b0;
    repeat (3) @(negedge iclk);
    checks++;
    if ({o_tbl_addr, o_tbl_rd, o_fwd_valid, o_fwd_mask, o_fwd_flood, o_drop_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got addr=%h rd=%b valid=%b mask=%b flood=%b drop=%0d exp all 0",
               o_tbl_addr, o_tbl_rd, o_fwd_valid, o_fwd_mask, o_fwd_flood, o_drop_cnt);
    end
    irst = 1'b0;
    @(negedge iclk);
  endtask

  task automatic test_unicast_hit;
    frame_and_check(2'd1, 48'h0011_2233_0456, 2'd3, 9'd300, 4'b1000, 1'b0, 1'b1, 4, "unicast");
    repeat (2) @(negedge iclk);
  endtask

  task automatic test_broadcast;
    frame_and_check(2'd0, 48'hFFFF_FFFF_FFFF, 2'd2, 9'd7, 4'b1110, 1'b1, 1'b1, 2, "broadcast");
    frame_and_check(2'd3, 48'h0100_5E00_0010, 2'd1, 9'd50, 4'b0111, 1'b1, 1'b1, 0, "multicast");
    repeat (2) @(negedge iclk);
  endtask

  task automatic test_aged;
    frame_and_check(2'd2, 48'h0000_0000_0123, 2'd1, 9'd0, 4'b1011, 1'b1, 1'b1, 1, "aged");
    repeat (2) @(negedge iclk);
  endtask

  task automatic test_filter;
    frame_and_check(2'd1, 48'h00AA_BBCC_0077, 2'd1, 9'd5, 4'b0000, 1'b0, 1'b1, 3, "filter");
    repeat (2) @(negedge iclk);
  endtask

  task automatic test_backpressure;
    logic bad;
    frame_and_check(2'd0, 48'h0000_0000_0010, 2'd2, 9'd9, 4'b0100, 1'b0, 1'b0, 0, "bp_first");
    repeat (2) begin
      @(negedge iclk);
      checks++;
      if (o_fwd_valid !== 1'b1 || o_fwd_mask !== 4'b0100 || o_fwd_flood !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_hold got valid=%b mask=%b flood=%b exp 1/0100/0",
                 o_fwd_valid, o_fwd_mask, o_fwd_flood);
      end
    end
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      @(negedge iclk);
      i_dv = 1'b1; irx_d = 8'h10 + 8'(b); i_port_num = 2'd3;
      if (o_tbl_rd !== 1'b0 || o_fwd_mask !== 4'b0100) bad = 1'b1;
    end
    expDrop++;
    @(negedge iclk);
    i_dv = 1'b0;
    checks++;
    if (bad || o_tbl_rd !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_second_frame got rd or mask change=1 exp=0");
    end
    @(negedge iclk);
    checks++;
    if (o_drop_cnt !== 16'(expDrop)) begin
      failures++;
      $display("[TB] FAIL bp_drop got=%0d exp=%0d", o_drop_cnt, expDrop);
    end
    checks++;
    if (o_fwd_valid !== 1'b1 || o_fwd_mask !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL bp_still_pending got valid=%b mask=%b exp 1/0100", o_fwd_valid, o_fwd_mask);
    end
    i_fwd_ready = 1'b1;
    @(negedge iclk);
    checks++;
    if (o_fwd_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_release got valid=%b exp=0", o_fwd_valid);
    end
    bad = 1'b0;
    repeat (8) begin
      @(negedge iclk);
      if (o_fwd_valid !== 1'b0 || o_tbl_rd !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL bp_no_second_decision got extra valid/rd=1 exp=0");
    end
  endtask

  task automatic test_simultaneous;
    logic bad;
    frame_and_check(2'd3, 48'h0000_0000_0020, 2'd0, 9'd1, 4'b0001, 1'b0, 1'b0, 0, "simul");
    @(negedge iclk);
    i_fwd_ready = 1'b1; i_dv = 1'b1; irx_d = 8'h55; i_port_num = 2'd0;
    expDrop++;
    @(negedge iclk);
    checks++;
    if (o_fwd_valid !== 1'b0 || o_drop_cnt !== 16'(expDrop)) begin
      failures++;
      $display("[TB] FAIL simul_skip got valid=%b drop=%0d exp valid=0 drop=%0d",
               o_fwd_valid, o_drop_cnt, expDrop);
    end
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      irx_d = 8'h60 + 8'(b);
      @(negedge iclk);
      if (o_tbl_rd !== 1'b0 || o_fwd_valid !== 1'b0) bad = 1'b1;
    end
    i_dv = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL simul_frame_skipped got rd/valid=1 exp=0");
    end
    repeat (2) @(negedge iclk);
  endtask

  task automatic test_runt;
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge iclk);
      i_dv = 1'b1; irx_d = 8'h30 + 8'(b); i_port_num = 2'd2;
    end
    @(negedge iclk);
    i_dv = 1'b0;
    repeat (6) begin
      @(negedge iclk);
      if (o_tbl_rd !== 1'b0 || o_fwd_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("[TB] FAIL runt got rd/valid=1 exp=0");
    end
    frame_and_check(2'd2, 48'h0000_0000_0321, 2'd0, 9'd12, 4'b0001, 1'b0, 1'b1, 0, "after_runt");
    repeat (2) @(negedge iclk);
  endtask

  task automatic test_reset_in_hold;
    frame_and_check(2'd1, 48'h0000_0000_0456, 2'd3, 9'd4, 4'b1000, 1'b0, 1'b0, 0, "rst_hold");
    @(negedge iclk);
    irst = 1'b1;
    @(negedge iclk);
    irst = 1'b0;
    expDrop = 0;
    checks++;
    if (o_fwd_valid !== 1'b0 || o_fwd_mask !== 4'b0000 || o_drop_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL rst_hold_clear got valid=%b mask=%b drop=%0d exp 0/0000/0",
               o_fwd_valid, o_fwd_mask, o_drop_cnt);
    end
    frame_and_check(2'd0, 48'h0011_2233_0456, 2'd3, 9'd300, 4'b1000, 1'b0, 1'b1, 2, "after_rst");
    repeat (2) @(negedge iclk);
  endtask

  task automatic test_back_to_back;
    frame_and_check(2'd0, 48'h0000_0000_1111, 2'd1, 9'd20, 4'b0010, 1'b0, 1'b1, 2, "b2b_first");
    frame_and_check(2'd3, 48'h0000_0000_2222, 2'd2, 9'd21, 4'b0100, 1'b0, 1'b1, 0, "b2b_second");
    repeat (2) @(negedge iclk);
  endtask

  initial begin
    test_reset();
    test_unicast_hit();
    test_broadcast();
    test_aged();
    test_filter();
    test_backpressure();
    test_simultaneous();
    test_runt();
    test_reset_in_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
